// File: rtl/stream_serializer_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// | Module   : stream_serializer_if                                           |
// | Purpose  : Vector-in / beat-out handshake bundle for stream_serializer.   |
// | Revision : 1.0                                                            |
// -----------------------------------------------------------------------------
interface stream_serializer_if #(
   parameter int SIZE  = 8,
   parameter int WIDTH = 16,
   parameter int LANES = 1
);
   localparam int LEN_W = $clog2(SIZE + 1);

   logic                        in_valid;
   logic                        in_ready;
   logic [SIZE-1:0][WIDTH-1:0]  in_data;
   logic [LEN_W-1:0]            in_len;
   logic                        out_valid;
   logic                        out_ready;
   logic [LANES-1:0][WIDTH-1:0] out_data;
   logic [LANES-1:0]            out_mask;
   logic                        out_last;

   modport master (
      output in_valid, in_data, in_len, out_ready,
      input  in_ready, out_valid, out_data, out_mask, out_last
   );

   modport slave (
      input  in_valid, in_data, in_len, out_ready,
      output in_ready, out_valid, out_data, out_mask, out_last
   );
endinterface
`default_nettype wire

// File: rtl/stream_serializer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// | Module   : stream_serializer                                              |
// | Purpose  : Accepts a vector of up to SIZE words and emits it LANES words  |
// |            per beat, lowest index first, with mask and last flag.         |
// | Option   : STREAM_SERIALIZER_PREFETCH_EN adds a one-deep holding register |
// |            so in_ready has no combinational path from out_ready.          |
// | Revision : 1.0                                                            |
// -----------------------------------------------------------------------------
module stream_serializer #(
   parameter int SIZE  = 8,
   parameter int WIDTH = 16,
   parameter int LANES = 1
) (
   input  wire logic          clk,
   input  wire logic          rst,
   stream_serializer_if.slave bus
);
   localparam int BEATS = SIZE / LANES;
   localparam int LEN_W = $clog2(SIZE + 1);

   typedef logic [SIZE-1:0][WIDTH-1:0]  vec_t;
   typedef logic [LANES-1:0][WIDTH-1:0] lanes_t;
   typedef logic [LANES-1:0]            mask_t;
   typedef logic [LEN_W-1:0]            len_t;
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   generate
      if (SIZE < 1 || LANES < 1 || LANES > SIZE || (LANES * BEATS) != SIZE) begin : g_bad_params
         $error("stream_serializer: LANES must lie in 1..SIZE and divide SIZE");
      end
   endgenerate

   state_t state_q;
   vec_t   vec_q;
   len_t   rem_q;
   logic   out_valid_q;
   logic   out_last_q;
   mask_t  out_mask_q;
   lanes_t out_data_q;

   len_t   in_len_eff;
   logic   in_fire;
   logic   out_fire;
   logic   load_en;
   vec_t   src_vec;
   len_t   src_len;
   vec_t   vec_d;
   len_t   rem_d;

`ifdef STREAM_SERIALIZER_PREFETCH_EN
   logic   hold_full_q;
   vec_t   hold_vec_q;
   len_t   hold_len_q;
`endif

   // rem counts words still to send, current beat included; lane i is live while i < rem.
   function automatic mask_t f_mask(input len_t rem);
      mask_t m;
      for (int i = 0; i < LANES; i++) begin
         m[i] = (rem > LEN_W'(i));
      end
      return m;
   endfunction

   function automatic lanes_t f_lanes(input vec_t vec, input len_t rem);
      lanes_t d;
      for (int i = 0; i < LANES; i++) begin
         d[i] = (rem > LEN_W'(i)) ? vec[i] : '0;
      end
      return d;
   endfunction

   assign in_fire  = bus.in_valid && bus.in_ready;
   assign out_fire = out_valid_q && bus.out_ready;

   always_comb begin
      in_len_eff = bus.in_len;
      if (bus.in_len == '0 || bus.in_len > LEN_W'(SIZE)) begin
         in_len_eff = LEN_W'(SIZE);
      end
   end

   // Select what the active register takes next: the following beat of the
   // current vector, or a fresh vector (parked one first when prefetching).
   always_comb begin
      src_vec = bus.in_data;
      src_len = in_len_eff;
      load_en = 1'b0;
`ifdef STREAM_SERIALIZER_PREFETCH_EN
      if (hold_full_q) begin
         src_vec = hold_vec_q;
         src_len = hold_len_q;
      end
      if (state_q == IDLE) begin
         load_en = in_fire;
      end else begin
         load_en = out_fire && (!out_last_q || hold_full_q || in_fire);
      end
`else
      if (state_q == IDLE) begin
         load_en = in_fire;
      end else begin
         load_en = out_fire && (!out_last_q || in_fire);
      end
`endif
      if (state_q == SHIFT && !out_last_q) begin
         vec_d = vec_q >> (LANES * WIDTH);
         rem_d = rem_q - LEN_W'(LANES);
      end else begin
         vec_d = src_vec;
         rem_d = src_len;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_mask_q  <= '0;
`ifdef STREAM_SERIALIZER_PREFETCH_EN
         hold_full_q <= 1'b0;
`endif
      end else begin
         if (load_en) begin
            state_q     <= SHIFT;
            vec_q       <= vec_d;
            rem_q       <= rem_d;
            out_valid_q <= 1'b1;
            out_last_q  <= (rem_d <= LEN_W'(LANES));
            out_mask_q  <= f_mask(rem_d);
            out_data_q  <= f_lanes(vec_d, rem_d);
         end else if (out_fire) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_mask_q  <= '0;
         end
`ifdef STREAM_SERIALIZER_PREFETCH_EN
         if (out_fire && out_last_q && hold_full_q) begin
            hold_full_q <= 1'b0;
         end else if (in_fire && state_q == SHIFT && !(out_fire && out_last_q)) begin
            hold_full_q <= 1'b1;
            hold_vec_q  <= bus.in_data;
            hold_len_q  <= in_len_eff;
         end
`endif
      end
   end

`ifdef STREAM_SERIALIZER_PREFETCH_EN
   assign bus.in_ready = !hold_full_q;
`else
   assign bus.in_ready = (state_q == IDLE) || (out_fire && out_last_q);
`endif

   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_mask  = out_mask_q;
   assign bus.out_data  = out_data_q;
endmodule
`default_nettype wire

// File: tb/tb_stream_serializer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// | Module   : tb_stream_serializer                                           |
// | Purpose  : Directed, table-driven checks of stream_serializer in several  |
// |            SIZE/LANES configurations.                                     |
// | Revision : 1.0                                                            |
// -----------------------------------------------------------------------------
module tb_stream_serializer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   stream_serializer_if #(.SIZE(8), .WIDTH(16), .LANES(1)) if_a ();
   stream_serializer_if #(.SIZE(8), .WIDTH(16), .LANES(4)) if_b ();
   stream_serializer_if #(.SIZE(8), .WIDTH(16), .LANES(2)) if_c ();
   stream_serializer_if #(.SIZE(4), .WIDTH(16), .LANES(1)) if_d ();

   stream_serializer #(.SIZE(8), .WIDTH(16), .LANES(1)) u_a (.clk(clk), .rst(rst), .bus(if_a));
   stream_serializer #(.SIZE(8), .WIDTH(16), .LANES(4)) u_b (.clk(clk), .rst(rst), .bus(if_b));
   stream_serializer #(.SIZE(8), .WIDTH(16), .LANES(2)) u_c (.clk(clk), .rst(rst), .bus(if_c));
   stream_serializer #(.SIZE(4), .WIDTH(16), .LANES(1)) u_d (.clk(clk), .rst(rst), .bus(if_d));

   typedef struct {
      logic [63:0] data;
      logic [3:0]  mask;
      logic        last;
      int          cyc;
   } beat_t;

   typedef struct {
      logic [3:0]  len;
      int          nbeats;
      logic [63:0] first_data;
      logic [3:0]  first_mask;
      logic [63:0] last_data;
      logic [3:0]  last_mask;
   } tv_t;

   beat_t q_a[$];
   beat_t q_b[$];
   beat_t q_c[$];
   beat_t q_d[$];
   bit    rdy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   // Beats are logged mid-cycle, once inputs for that cycle are settled.
   always @(negedge clk) begin
      #2;
      if (!rst && if_a.out_valid && if_a.out_ready) q_a.push_back('{64'(if_a.out_data), 4'(if_a.out_mask), if_a.out_last, cyc});
      if (!rst && if_b.out_valid && if_b.out_ready) q_b.push_back('{64'(if_b.out_data), 4'(if_b.out_mask), if_b.out_last, cyc});
      if (!rst && if_c.out_valid && if_c.out_ready) q_c.push_back('{64'(if_c.out_data), 4'(if_c.out_mask), if_c.out_last, cyc});
      if (!rst && if_d.out_valid && if_d.out_ready) q_d.push_back('{64'(if_d.out_data), 4'(if_d.out_mask), if_d.out_last, cyc});
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0][15:0] words8(input logic [15:0] base);
      logic [7:0][15:0] r;
      for (int i = 0; i < 8; i++) r[i] = base + 16'(i);
      return r;
   endfunction

   function automatic logic [3:0][15:0] words4(input logic [15:0] base);
      logic [3:0][15:0] r;
      for (int i = 0; i < 4; i++) r[i] = base + 16'(i);
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tv_t         tv[6];
      int          c0;
      int          accepts;
      int          acc_cyc[2];
      logic        prev_valid;
      logic        prev_ready;
      logic [63:0] prev_data;
      logic [3:0]  prev_mask;
      logic        prev_last;
      int          nb;

      tv[0] = '{4'd6, 2, 64'h00A3_00A2_00A1_00A0, 4'hF, 64'h0000_0000_00A5_00A4, 4'h3};
      tv[1] = '{4'd8, 2, 64'h00A3_00A2_00A1_00A0, 4'hF, 64'h00A7_00A6_00A5_00A4, 4'hF};
      tv[2] = '{4'd1, 1, 64'h0000_0000_0000_00A0, 4'h1, 64'h0000_0000_0000_00A0, 4'h1};
      tv[3] = '{4'd4, 1, 64'h00A3_00A2_00A1_00A0, 4'hF, 64'h00A3_00A2_00A1_00A0, 4'hF};
      tv[4] = '{4'd0, 2, 64'h00A3_00A2_00A1_00A0, 4'hF, 64'h00A7_00A6_00A5_00A4, 4'hF};
      tv[5] = '{4'd5, 2, 64'h00A3_00A2_00A1_00A0, 4'hF, 64'h0000_0000_0000_00A4, 4'h1};

      if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.in_len = '0; if_a.out_ready = 1'b1;
      if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.in_len = '0; if_b.out_ready = 1'b1;
      if_c.in_valid = 1'b0; if_c.in_data = '0; if_c.in_len = '0; if_c.out_ready = 1'b1;
      if_d.in_valid = 1'b0; if_d.in_data = '0; if_d.in_len = '0; if_d.out_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_a_out_valid", 64'(if_a.out_valid), 64'd0);
      chk("rst_a_out_last",  64'(if_a.out_last),  64'd0);
      chk("rst_a_out_mask",  64'(if_a.out_mask),  64'd0);
      chk("rst_a_in_ready",  64'(if_a.in_ready),  64'd1);
      chk("rst_b_out_mask",  64'(if_b.out_mask),  64'd0);
      chk("rst_c_out_valid", 64'(if_c.out_valid), 64'd0);
      chk("rst_d_in_ready",  64'(if_d.in_ready),  64'd1);

      // LANES=1, len=8: one word per cycle starting the cycle after acceptance
      @(negedge clk);
      if_a.in_valid = 1'b1; if_a.in_data = words8(16'h10); if_a.in_len = 4'd8;
      #1;
      chk("a8_in_ready", 64'(if_a.in_ready), 64'd1);
      c0 = cyc;
      @(negedge clk);
      if_a.in_valid = 1'b0;
      for (int k = 0; k < 20 && q_a.size() < 8; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("a8_beats", 64'(q_a.size()), 64'd8);
      for (int k = 0; k < q_a.size() && k < 8; k++) begin
         chk($sformatf("a8_data%0d", k), q_a[k].data, 64'(16'h10 + k));
         chk($sformatf("a8_last%0d", k), 64'(q_a[k].last), 64'(k == 7));
         chk($sformatf("a8_mask%0d", k), 64'(q_a[k].mask), 64'd1);
         chk($sformatf("a8_cyc%0d", k),  64'(q_a[k].cyc), 64'(c0 + 1 + k));
      end
      q_a.delete();

      // LANES=4 vector table
      for (int t = 0; t < 6; t++) begin
         q_b.delete();
         @(negedge clk);
         if_b.in_valid = 1'b1; if_b.in_data = words8(16'hA0); if_b.in_len = tv[t].len;
         @(negedge clk);
         if_b.in_valid = 1'b0;
         for (int k = 0; k < 10 && q_b.size() < tv[t].nbeats; k++) @(negedge clk);
         repeat (3) @(negedge clk);
         chk($sformatf("b%0d_beats", t), 64'(q_b.size()), 64'(tv[t].nbeats));
         if (q_b.size() > 0) begin
            nb = q_b.size() - 1;
            chk($sformatf("b%0d_first_data", t), q_b[0].data, tv[t].first_data);
            chk($sformatf("b%0d_first_mask", t), 64'(q_b[0].mask), 64'(tv[t].first_mask));
            chk($sformatf("b%0d_first_last", t), 64'(q_b[0].last), 64'(tv[t].nbeats == 1));
            chk($sformatf("b%0d_last_data", t),  q_b[nb].data, tv[t].last_data);
            chk($sformatf("b%0d_last_mask", t),  64'(q_b[nb].mask), 64'(tv[t].last_mask));
            chk($sformatf("b%0d_last_flag", t),  64'(q_b[nb].last), 64'd1);
         end
      end

      // LANES=2 backpressure: outputs must hold while stalled
      @(negedge clk);
      if_c.in_valid = 1'b1; if_c.in_data = words8(16'h40); if_c.in_len = 4'd8; if_c.out_ready = 1'b1;
      @(negedge clk);
      if_c.in_valid = 1'b0;
      prev_valid = 1'b0; prev_ready = 1'b1; prev_data = '0; prev_mask = '0; prev_last = 1'b0;
      for (int k = 0; k < 40 && q_c.size() < 4; k++) begin
         if_c.out_ready = rdy_pat[k % 4];
         #1;
         if (prev_valid && !prev_ready) begin
            chk($sformatf("c_stall%0d_valid", k), 64'(if_c.out_valid), 64'd1);
            chk($sformatf("c_stall%0d_data", k),  64'(if_c.out_data), prev_data);
            chk($sformatf("c_stall%0d_mask", k),  64'(if_c.out_mask), 64'(prev_mask));
            chk($sformatf("c_stall%0d_last", k),  64'(if_c.out_last), 64'(prev_last));
         end
         prev_valid = if_c.out_valid; prev_ready = if_c.out_ready;
         prev_data = 64'(if_c.out_data); prev_mask = 4'(if_c.out_mask); prev_last = if_c.out_last;
         @(negedge clk);
      end
      if_c.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("c_beats", 64'(q_c.size()), 64'd4);
      chk("c_idle_after", 64'(if_c.out_valid), 64'd0);
      for (int b = 0; b < q_c.size() && b < 4; b++) begin
         chk($sformatf("c_data%0d", b), q_c[b].data, 64'({16'(16'h41 + 2 * b), 16'(16'h40 + 2 * b)}));
         chk($sformatf("c_mask%0d", b), 64'(q_c[b].mask), 64'd3);
         chk($sformatf("c_last%0d", b), 64'(q_c[b].last), 64'(b == 3));
      end

      // Back-to-back vectors, in_valid held high
      @(negedge clk);
      accepts = 0; acc_cyc[0] = -1; acc_cyc[1] = -1;
      if_a.in_valid = 1'b1; if_a.in_data = words8(16'h20); if_a.in_len = 4'd4;
      for (int k = 0; k < 30 && accepts < 2; k++) begin
         #1;
         if (if_a.in_ready) begin
            acc_cyc[accepts] = cyc;
            accepts++;
         end
         @(negedge clk);
         if (accepts == 1) if_a.in_data = words8(16'h30);
      end
      if_a.in_valid = 1'b0;
      for (int k = 0; k < 20 && q_a.size() < 8; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("bb_accepts", 64'(accepts), 64'd2);
      chk("bb_beats", 64'(q_a.size()), 64'd8);
      if (q_a.size() >= 8) begin
         chk("bb_first_latency", 64'(q_a[0].cyc), 64'(acc_cyc[0] + 1));
`ifdef STREAM_SERIALIZER_PREFETCH_EN
         chk("bb_second_accept", 64'(acc_cyc[1]), 64'(acc_cyc[0] + 1));
`else
         chk("bb_second_accept", 64'(acc_cyc[1]), 64'(q_a[3].cyc));
`endif
         for (int k = 0; k < 8; k++) begin
            chk($sformatf("bb_data%0d", k), q_a[k].data, 64'((k < 4) ? (16'h20 + k) : (16'h30 + k - 4)));
            chk($sformatf("bb_last%0d", k), 64'(q_a[k].last), 64'(k == 3 || k == 7));
            chk($sformatf("bb_cyc%0d", k),  64'(q_a[k].cyc), 64'(q_a[0].cyc + k));
         end
      end
      q_a.delete();

      // in_len=0 on SIZE=4 means a full vector
      @(negedge clk);
      if_d.in_valid = 1'b1; if_d.in_data = words4(16'h50); if_d.in_len = 3'd0;
      @(negedge clk);
      if_d.in_valid = 1'b0;
      for (int k = 0; k < 20 && q_d.size() < 4; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("d_len0_beats", 64'(q_d.size()), 64'd4);
      for (int k = 0; k < q_d.size() && k < 4; k++) begin
         chk($sformatf("d_data%0d", k), q_d[k].data, 64'(16'h50 + k));
         chk($sformatf("d_last%0d", k), 64'(q_d[k].last), 64'(k == 3));
      end

      // Reset in the middle of a vector, then a fresh vector
      @(negedge clk);
      if_a.in_valid = 1'b1; if_a.in_data = words8(16'h60); if_a.in_len = 4'd8;
      @(negedge clk);
      if_a.in_valid = 1'b0;
      for (int k = 0; k < 20 && q_a.size() < 2; k++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mrst_out_valid", 64'(if_a.out_valid), 64'd0);
      chk("mrst_in_ready",  64'(if_a.in_ready),  64'd1);
      chk("mrst_out_last",  64'(if_a.out_last),  64'd0);
      chk("mrst_out_mask",  64'(if_a.out_mask),  64'd0);
      chk("mrst_beats_before", 64'(q_a.size()), 64'd2);
      q_a.delete();
      if_a.in_valid = 1'b1; if_a.in_data = words8(16'h70); if_a.in_len = 4'd3;
      @(negedge clk);
      if_a.in_valid = 1'b0;
      for (int k = 0; k < 20 && q_a.size() < 3; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("mrst_new_beats", 64'(q_a.size()), 64'd3);
      for (int k = 0; k < q_a.size() && k < 3; k++) begin
         chk($sformatf("mrst_new_data%0d", k), q_a[k].data, 64'(16'h70 + k));
         chk($sformatf("mrst_new_last%0d", k), 64'(q_a[k].last), 64'(k == 2));
      end
      q_a.delete();

`ifdef STREAM_SERIALIZER_PREFETCH_EN
      // Second vector offered during beat 1 of the first is parked and follows with no gap
      @(negedge clk);
      if_a.in_valid = 1'b1; if_a.in_data = words8(16'h80); if_a.in_len = 4'd4;
      @(negedge clk);
      if_a.in_valid = 1'b0;
      @(negedge clk);
      if_a.in_valid = 1'b1; if_a.in_data = words8(16'h90); if_a.in_len = 4'd2;
      #1;
      chk("pf_ready_offer", 64'(if_a.in_ready), 64'd1);
      @(negedge clk);
      if_a.in_valid = 1'b0;
      #1;
      chk("pf_ready_beat2", 64'(if_a.in_ready), 64'd0);
      @(negedge clk);
      #1;
      chk("pf_ready_beat3", 64'(if_a.in_ready), 64'd0);
      @(negedge clk);
      #1;
      chk("pf_ready_after", 64'(if_a.in_ready), 64'd1);
      for (int k = 0; k < 20 && q_a.size() < 6; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("pf_beats", 64'(q_a.size()), 64'd6);
      for (int k = 0; k < q_a.size() && k < 6; k++) begin
         chk($sformatf("pf_data%0d", k), q_a[k].data, 64'((k < 4) ? (16'h80 + k) : (16'h90 + k - 4)));
         chk($sformatf("pf_cyc%0d", k),  64'(q_a[k].cyc), 64'(q_a[0].cyc + k));
         chk($sformatf("pf_last%0d", k), 64'(q_a[k].last), 64'(k == 3 || k == 5));
      end
      q_a.delete();
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/stream_serializer.md
Name: stream_serializer

Overview:
- Parametrised vector-to-stream serializer for the accelerator datapath: accepts a vector of up to SIZE words, each WIDTH bits, in one handshake.
- Emits the vector as a stream of LANES words per beat, lowest index first.
- Adds valid/ready flow control on both sides, variable vector length, a per-beat lane mask and a last-beat flag.
- Sits between parallel result registers (neuron outputs, accumulator banks) and narrow consumers (memory write port, activation unit).

Parameters:
- SIZE, 8, maximum words per vector; must be >= 1.
- WIDTH, 16, bits per word.
- LANES, 1, words emitted per output beat; 1 <= LANES <= SIZE; SIZE % LANES == 0 required, elaboration error otherwise.
- BEATS, SIZE/LANES, derived localparam, not overridable.
- LEN_W, $clog2(SIZE+1), derived localparam, width of the length field.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  vector present on in_data/in_len.
- in_ready  out  1  block can accept a vector this cycle.
- in_data  in  SIZE x WIDTH (packed [SIZE-1:0][WIDTH-1:0])  vector; word 0 is emitted first.
- in_len  in  LEN_W  number of valid words, 1..SIZE; a value of 0 is treated as SIZE.
- out_valid  out  1  out_data holds a beat.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  LANES x WIDTH  current beat; lane 0 holds the lowest word index.
- out_mask  out  LANES  per-lane valid bits; all ones except possibly on the last beat.
- out_last  out  1  final beat of the current vector.

Behaviour:
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_valid and out_ready must not be used combinationally to derive out_valid.
- Reset (rst=1 at a clock edge): state IDLE, out_valid=0, out_last=0, out_mask=0, beat counter=0, in_ready=1 the cycle after reset. out_data after reset is don't-care; benches must not check it while out_valid=0.
- Reset mid-vector: remaining beats are discarded. No partial beat is emitted after reset.
- FSM has two states:
  - IDLE: out_valid=0, in_ready=1. On input transfer: latch in_data, compute nbeats = ceil(len/LANES), set beat=0, go to SHIFT.
  - SHIFT: out_valid=1. out_data = words [beat*LANES +: LANES] of the latched vector.
- Output on each SHIFT beat:
  - out_last = (beat == nbeats-1).
  - out_mask bit i = (beat*LANES + i < len).
  - Lanes whose mask bit is 0 drive 0.
- SHIFT transitions:
  - Output transfer with out_last=0: beat increments, vector held.
  - Output transfer with out_last=1 and no input transfer in the same cycle: go to IDLE.
  - No output transfer: all outputs hold stable (AXI-style, no retraction).
- in_ready in SHIFT = out_valid && out_ready && out_last (combinational path from out_ready).
  - Simultaneous last-beat output transfer and input transfer: the new vector is latched, beat=0, and the FSM stays in SHIFT.
  - The first beat of the new vector appears the next cycle, giving zero bubble.
- Latency: input transfer at cycle N gives first beat valid at N+1. A vector of len L takes ceil(L/LANES) beats at full throughput.
- Single-word vector (len=1, LANES=1): one beat with out_last=1 immediately.
- Shifting is done by index or by shifting the latched vector down by LANES words per beat. Either is acceptable; the observable behaviour must be identical.

Optional Feature:
- Macro: STREAM_SERIALIZER_PREFETCH_EN.
- When defined:
  - Adds one holding register (data+len+full flag).
  - in_ready = !hold_full, registered, with no combinational path from out_ready.
  - A vector accepted while in SHIFT is parked in the holding register.
  - On the last-beat output transfer, the parked vector moves to the active register with no bubble.
  - If the holding register is empty at that point, the FSM returns to IDLE.
  - Reset clears hold_full.
- When undefined: behaviour exactly as above; no holding register is instantiated.

Test Plan:
- SIZE=8, LANES=1, len=8, in_data words 0..7 = 0x10..0x17, out_ready=1 → 8 beats 0x10..0x17 on cycles N+1..N+8, out_last only on the 8th beat, out_mask=1 on every beat.
- SIZE=8, LANES=4, len=6, words 0xA0..0xA7 → beat0 {A3,A2,A1,A0} mask 4'b1111; beat1 {0,0,A5,A4} mask 4'b0011 out_last=1.
- Backpressure: LANES=2, len=8, out_ready toggles 1,0,0,1,... → out_data, out_mask and out_last stay stable while stalled; exactly 4 beats total, no duplicates and no drops.
- Back-to-back: two vectors len=4, LANES=1, in_valid held high, out_ready=1 → 8 consecutive valid beats with no out_valid gap; the second vector is accepted on the cycle of the first vector's out_last.
- in_len=0 with SIZE=4, LANES=1 → 4 beats emitted, same as len=4.
- rst asserted after beat 2 of an 8-beat vector → next cycle out_valid=0 and in_ready=1; a new vector then emits from its word 0.
- With STREAM_SERIALIZER_PREFETCH_EN: a second vector is offered during beat 1 of the first → in_ready=1 that cycle, then in_ready=0 until handover; the stream continues with no gap.
